// File: rtl/bar_animator.sv
// bar_animator: a prescaled tick steps up to three bar positions (hold / wrap / ping-pong / steer),
// and the pixel colour is set by comparing x/y against them. Define BAR_ANIMATOR_PIXEL_REG_EN to register red/green/blue.
module bar_animator #(
  parameter int n_chan        = 2,
  parameter int w_div         = 20,
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int w_red         = 4,
  parameter int w_green       = 4,
  parameter int w_blue        = 4,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height),
  parameter int w_p           = $clog2(screen_width + screen_height)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [w_div-1:0]     period,
  input  logic [2*n_chan-1:0]  mode,
  input  logic [n_chan-1:0]    inc,
  input  logic [n_chan-1:0]    dec,
  input  logic [w_x-1:0]       x,
  input  logic [w_y-1:0]       y,
  output logic                 tick,
  output logic [16*n_chan-1:0] pos,
  output logic [w_red-1:0]     red,
  output logic [w_green-1:0]   green,
  output logic [w_blue-1:0]    blue
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  function automatic logic [w_p-1:0] lim_of(input int c);
    case (c)
      0:       return w_p'(screen_width);
      1:       return w_p'(screen_width + screen_height - 1);
      default: return w_p'(screen_height);
    endcase
  endfunction

  logic [w_div-1:0] cnt_q, cnt_d;
  logic [3*w_p-1:0] pos_cur;

  // Comparing with >= lets a shrinking period pull an overshot count straight back to 0.
  always_comb begin
    tick  = (cnt_q == '0) && !rst;
    cnt_d = (cnt_q >= period) ? '0 : cnt_q + w_div'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  for (genvar c = 0; c < 3; c++) begin : g_chan
    if (c < n_chan) begin : g_on
      localparam logic [w_p-1:0] lim      = lim_of(c);
      localparam logic [w_p-1:0] lim_m1   = lim - w_p'(1);
      localparam logic [w_p-1:0] lim_m2   = lim - w_p'(2);
      localparam logic [w_p-1:0] lim_half = lim >> 1;

      logic [w_p-1:0] pos_q, pos_d;
      dir_e           dir_q, dir_d;

      always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (tick) begin
          unique case (mode[2*c +: 2])
            2'b00: pos_d = pos_q;
            2'b01: pos_d = (pos_q == lim_m1) ? '0 : pos_q + w_p'(1);
            2'b10: begin
              if (dir_q == DIR_UP) begin
                if (pos_q == lim_m1) begin
                  dir_d = DIR_DOWN;
                  pos_d = lim_m2;
                end else begin
                  pos_d = pos_q + w_p'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  dir_d = DIR_UP;
                  pos_d = w_p'(1);
                end else begin
                  pos_d = pos_q - w_p'(1);
                end
              end
            end
            2'b11: begin
              // Re-centre from either end so steering can never leave 0..L-1.
              if (pos_q == '0 || pos_q == lim_m1) pos_d = lim_half;
              else if (inc[c] && !dec[c])         pos_d = pos_q + w_p'(1);
              else if (dec[c] && !inc[c])         pos_d = pos_q - w_p'(1);
              else                                pos_d = pos_q;
            end
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          pos_q <= lim_half;
          dir_q <= DIR_UP;
        end else begin
          pos_q <= pos_d;
          dir_q <= dir_d;
        end
      end

      assign pos[16*c +: 16]        = 16'(pos_q);
      assign pos_cur[c*w_p +: w_p]  = pos_q;
    end else begin : g_off
      assign pos_cur[c*w_p +: w_p]  = '0;
    end
  end

  logic [w_p-1:0] xy_sum;
  logic           red_hit, green_hit, blue_hit;

  always_comb begin
    xy_sum    = w_p'(x) + w_p'(y);
    red_hit   = w_p'(x) > pos_cur[0 +: w_p];
    green_hit = (n_chan >= 2) && (xy_sum > pos_cur[w_p +: w_p]);
    blue_hit  = (n_chan >= 3) && (w_p'(y) > pos_cur[2*w_p +: w_p]);
  end

`ifdef BAR_ANIMATOR_PIXEL_REG_EN
  logic [w_red-1:0]   red_q, red_d;
  logic [w_green-1:0] green_q, green_d;
  logic [w_blue-1:0]  blue_q, blue_d;

  always_comb begin
    red_d   = {w_red{red_hit}};
    green_d = {w_green{green_hit}};
    blue_d  = {w_blue{blue_hit}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;
`else
  always_comb begin
    red   = {w_red{red_hit}};
    green = {w_green{green_hit}};
    blue  = {w_blue{blue_hit}};
  end
`endif

endmodule

// File: tb/tb_bar_animator.sv
// Self-checking bench for bar_animator with three channels: directed corner cases plus randomized
// runs, all compared against a behavioural model of prescaler, positions and colours.
module tb_bar_animator;
  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] period;
  logic [5:0]  mode;
  logic [2:0]  inc, dec;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        tick;
  logic [47:0] pos;
  logic [3:0]  red, green, blue;

  bar_animator #(.n_chan(3)) dut (
    .clk(clk), .rst(rst), .period(period), .mode(mode), .inc(inc), .dec(dec),
    .x(x), .y(y), .tick(tick), .pos(pos), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_cnt;
  int m_pos [3];
  bit m_up  [3];
  int lim   [3] = '{640, 1119, 480};

  task automatic model_edge();
    if (rst) begin
      m_cnt = 0;
      for (int c = 0; c < 3; c++) begin
        m_pos[c] = lim[c] / 2;
        m_up[c]  = 1'b1;
      end
    end else begin
      if (m_cnt == 0) begin
        for (int c = 0; c < 3; c++) begin
          case (mode[2*c +: 2])
            2'd1: m_pos[c] = (m_pos[c] + 1) % lim[c];
            2'd2: begin
              if (m_up[c] && m_pos[c] == lim[c] - 1) begin
                m_up[c] = 1'b0; m_pos[c] = lim[c] - 2;
              end else if (!m_up[c] && m_pos[c] == 0) begin
                m_up[c] = 1'b1; m_pos[c] = 1;
              end else begin
                m_pos[c] += m_up[c] ? 1 : -1;
              end
            end
            2'd3: begin
              if (m_pos[c] == 0 || m_pos[c] == lim[c] - 1) m_pos[c] = lim[c] / 2;
              else m_pos[c] += int'(inc[c]) - int'(dec[c]);
            end
            default: ;
          endcase
        end
      end
      m_cnt = (m_cnt >= int'(period)) ? 0 : m_cnt + 1;
    end
  endtask

  task automatic clk_step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; period = '0; mode = '0; inc = '0; dec = '0; x = '0; y = '0;
    clk_step();
    clk_step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (tick !== 1'b1) begin n_bad++; $display("FAIL reset_tick got %b want 1", tick); end
    n_cmp++;
    if (pos[15:0] !== 16'd320) begin n_bad++; $display("FAIL reset_pos0 got %0d want 320", pos[15:0]); end
    n_cmp++;
    if (pos[31:16] !== 16'd559) begin n_bad++; $display("FAIL reset_pos1 got %0d want 559", pos[31:16]); end
    n_cmp++;
    if (pos[47:32] !== 16'd240) begin n_bad++; $display("FAIL reset_pos2 got %0d want 240", pos[47:32]); end
  endtask

  task automatic test_prescaler();
    logic exp_t;
    period = 20'd3; mode = '0;
    pulse_reset();
    for (int cyc = 0; cyc < 16; cyc++) begin
      exp_t = (cyc % 4 == 0);
      n_cmp++;
      if (tick !== exp_t) begin n_bad++; $display("FAIL presc_p3 cyc=%0d got %b want %b", cyc, tick, exp_t); end
      clk_step();
    end
    period = 20'd9;
    repeat (5) clk_step();
    n_cmp++;
    if (tick !== 1'b0) begin n_bad++; $display("FAIL presc_cnt5 got %b want 0", tick); end
    period = 20'd2;
    clk_step();
    n_cmp++;
    if (tick !== 1'b1) begin n_bad++; $display("FAIL presc_shrink got %b want 1", tick); end
    for (int k = 1; k <= 3; k++) begin
      clk_step();
      exp_t = (k == 3);
      n_cmp++;
      if (tick !== exp_t) begin n_bad++; $display("FAIL presc_p2 k=%0d got %b want %b", k, tick, exp_t); end
    end
    period = '0;
    clk_step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (tick !== 1'b1) begin n_bad++; $display("FAIL presc_p0 k=%0d got %b want 1", k, tick); end
      clk_step();
    end
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) period = 20'($urandom_range(0, 4));
      clk_step();
      exp_t = (m_cnt == 0);
      n_cmp++;
      if (tick !== exp_t) begin n_bad++; $display("FAIL presc_rand i=%0d got %b want %b", i, tick, exp_t); end
    end
  endtask

  task automatic test_wrap();
    period = '0; mode = 6'b000001;
    pulse_reset();
    repeat (319) clk_step();
    n_cmp++;
    if (pos[15:0] !== 16'd639) begin n_bad++; $display("FAIL wrap_top got %0d want 639", pos[15:0]); end
    clk_step();
    n_cmp++;
    if (pos[15:0] !== 16'h0000) begin n_bad++; $display("FAIL wrap_zero got %h want 0000", pos[15:0]); end
    n_cmp++;
    if (pos[31:16] !== 16'd559) begin n_bad++; $display("FAIL wrap_hold1 got %0d want 559", pos[31:16]); end
  endtask

  task automatic test_pingpong();
    period = '0; mode = 6'b001000;
    pulse_reset();
    repeat (559) clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd1118) begin n_bad++; $display("FAIL pp_top got %0d want 1118", pos[31:16]); end
    clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd1117) begin n_bad++; $display("FAIL pp_turn1 got %0d want 1117", pos[31:16]); end
    clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd1116) begin n_bad++; $display("FAIL pp_turn2 got %0d want 1116", pos[31:16]); end
    repeat (1116) clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd0) begin n_bad++; $display("FAIL pp_bottom got %0d want 0", pos[31:16]); end
    clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd1) begin n_bad++; $display("FAIL pp_bounce1 got %0d want 1", pos[31:16]); end
    clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd2) begin n_bad++; $display("FAIL pp_bounce2 got %0d want 2", pos[31:16]); end
  endtask

  task automatic test_steer();
    period = '0; mode = 6'b001100; inc = '0; dec = '0;
    pulse_reset();
    inc = 3'b010;
    repeat (3) clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd562) begin n_bad++; $display("FAIL steer_inc got %0d want 562", pos[31:16]); end
    dec = 3'b010;
    clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd562) begin n_bad++; $display("FAIL steer_both got %0d want 562", pos[31:16]); end
    inc = '0; dec = '0; mode = 6'b000100;
    repeat (556) clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd1118) begin n_bad++; $display("FAIL steer_to_top got %0d want 1118", pos[31:16]); end
    mode = 6'b001100;
    clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd559) begin n_bad++; $display("FAIL steer_top_centre got %0d want 559", pos[31:16]); end
    mode = 6'b000100;
    repeat (560) clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd0) begin n_bad++; $display("FAIL steer_to_zero got %0d want 0", pos[31:16]); end
    mode = 6'b001100;
    clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd559) begin n_bad++; $display("FAIL steer_zero_centre got %0d want 559", pos[31:16]); end
    dec = 3'b010;
    repeat (2) clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd557) begin n_bad++; $display("FAIL steer_dec got %0d want 557", pos[31:16]); end
    dec = '0;
  endtask

  task automatic test_random();
    logic exp_t;
    period = '0;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) mode = 6'($urandom);
      inc = 3'($urandom);
      dec = 3'($urandom);
      if ($urandom_range(0, 15) == 0) period = 20'($urandom_range(0, 2));
      clk_step();
      exp_t = (m_cnt == 0);
      n_cmp++;
      if (tick !== exp_t) begin n_bad++; $display("FAIL rand_tick i=%0d got %b want %b", i, tick, exp_t); end
      for (int c = 0; c < 3; c++) begin
        n_cmp++;
        if (pos[16*c +: 16] !== 16'(m_pos[c])) begin
          n_bad++;
          $display("FAIL rand_pos%0d i=%0d got %0d want %0d", c, i, pos[16*c +: 16], m_pos[c]);
        end
      end
    end
    inc = '0; dec = '0;
  endtask

  task automatic test_pixel();
    logic [3:0] er, eg, eb;
    period = '0; mode = '0;
    pulse_reset();
    x = 10'd321; y = 9'd0;
`ifdef BAR_ANIMATOR_PIXEL_REG_EN
    clk_step();
`else
    #1;
`endif
    n_cmp++;
    if (red !== 4'hF) begin n_bad++; $display("FAIL pix_red_on got %h want F", red); end
    x = 10'd320;
`ifdef BAR_ANIMATOR_PIXEL_REG_EN
    #1;
    n_cmp++;
    if (red !== 4'hF) begin n_bad++; $display("FAIL pix_latency got %h want F", red); end
    clk_step();
`else
    #1;
`endif
    n_cmp++;
    if (red !== 4'h0) begin n_bad++; $display("FAIL pix_red_off got %h want 0", red); end
`ifndef BAR_ANIMATOR_PIXEL_REG_EN
    clk_step();
`endif
    mode = 6'b010101;
    repeat ($urandom_range(0, 300)) clk_step();
    mode = '0;
    for (int i = 0; i < 40; i++) begin
      x = 10'($urandom_range(0, 639));
      y = 9'($urandom_range(0, 479));
      er = (int'(x) > m_pos[0]) ? 4'hF : 4'h0;
      eg = (int'(x) + int'(y) > m_pos[1]) ? 4'hF : 4'h0;
      eb = (int'(y) > m_pos[2]) ? 4'hF : 4'h0;
`ifdef BAR_ANIMATOR_PIXEL_REG_EN
      clk_step();
`else
      #1;
`endif
      n_cmp++;
      if ({red, green, blue} !== {er, eg, eb}) begin
        n_bad++;
        $display("FAIL pix_rand x=%0d y=%0d got %h%h%h want %h%h%h", x, y, red, green, blue, er, eg, eb);
      end
`ifndef BAR_ANIMATOR_PIXEL_REG_EN
      clk_step();
`endif
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    period = '0; mode = 6'b001000;
    pulse_reset();
    guard = 0;
    while (!(m_pos[1] == 700 && !m_up[1]) && guard < 3000) begin
      clk_step();
      guard++;
    end
    n_cmp++;
    if (guard >= 3000 || pos[31:16] !== 16'd700) begin
      n_bad++; $display("FAIL mid_reach700 got %0d want 700 (steps %0d)", pos[31:16], guard);
    end
    rst = 1'b1;
    clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd559) begin n_bad++; $display("FAIL mid_rst_pos1 got %0d want 559", pos[31:16]); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (tick !== 1'b1) begin n_bad++; $display("FAIL mid_rst_tick got %b want 1", tick); end
    clk_step();
    n_cmp++;
    if (pos[31:16] !== 16'd560) begin n_bad++; $display("FAIL mid_rst_dir_up got %0d want 560", pos[31:16]); end
  endtask

  initial begin
    test_reset();
    test_prescaler();
    test_wrap();
    test_pingpong();
    test_steer();
    test_random();
    test_pixel();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end
endmodule
